// File: rtl/axis_frame_gen.sv
// AXI4-Stream traffic generator: emits framed incrementing, constant or LFSR
// data with configurable frame length, frame count and inter-frame gap.
module axis_frame_gen #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LEN_WIDTH  = 16,
    parameter int                    GAP_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = 32'h80200003
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              pattern,
    input  logic [DATA_WIDTH-1:0]   seed,
    input  logic [LEN_WIDTH-1:0]    frame_len,
    input  logic [7:0]              num_frames,
    input  logic [GAP_WIDTH-1:0]    gap,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             frames_sent
);
    localparam int                    KEEP_W = DATA_WIDTH / 8;
    localparam logic [DATA_WIDTH-1:0] ONE_D  = 1;
    localparam logic [LEN_WIDTH-1:0]  ONE_L  = 1;
    localparam logic [GAP_WIDTH-1:0]  ONE_G  = 1;
    localparam logic [KEEP_W-1:0]     KEEP_1 = '1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                 state;
    logic [1:0]             cfg_pattern;
    logic [DATA_WIDTH-1:0]  cfg_seed;
    logic [LEN_WIDTH-1:0]   cfg_len;
    logic [7:0]             cfg_num;
    logic [GAP_WIDTH-1:0]   cfg_gap;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic                   stop_seen;

    logic [LEN_WIDTH-1:0]   len_in;
    logic [DATA_WIDTH-1:0]  seed_in;
    logic [15:0]            fs_inc;
    logic                   stop_now;
    logic                   run_end;

    function automatic logic [DATA_WIDTH-1:0] next_data(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [1:0]            pat);
        case (pat)
            2'b01:   return d;
            2'b10:   return (d >> 1) ^ (d[0] ? LFSR_POLY : '0);
            default: return d + ONE_D;
        endcase
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
    assign len_in   = (frame_len == '0) ? ONE_L : frame_len;
    assign seed_in  = (pattern == 2'b10 && seed == '0) ? ONE_D : seed;
    assign fs_inc   = frames_sent + 16'd1;
    assign stop_now = stop_seen | stop;
    assign run_end  = stop_now | ((cfg_num != 8'd0) && (fs_inc == {8'd0, cfg_num}));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            cfg_pattern   <= '0;
            cfg_seed      <= '0;
            cfg_len       <= '0;
            cfg_num       <= '0;
            cfg_gap       <= '0;
            gap_cnt       <= '0;
            beat_cnt      <= '0;
            stop_seen     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tkeep  <= '0;
            m_axis_tstrb  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frames_sent   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_pattern   <= pattern;
                        cfg_seed      <= seed_in;
                        cfg_len       <= len_in;
                        cfg_num       <= num_frames;
                        cfg_gap       <= gap;
                        beat_cnt      <= '0;
                        stop_seen     <= 1'b0;
                        frames_sent   <= '0;
                        m_axis_tdata  <= seed_in;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (len_in == ONE_L);
                        m_axis_tkeep  <= KEEP_1;
                        m_axis_tstrb  <= KEEP_1;
                        busy          <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (stop) stop_seen <= 1'b1;
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (!m_axis_tlast) begin
                            beat_cnt     <= beat_cnt + ONE_L;
                            m_axis_tdata <= next_data(m_axis_tdata, cfg_pattern);
                            m_axis_tlast <= (beat_cnt + ONE_L == cfg_len - ONE_L);
                        end else begin
                            frames_sent <= fs_inc;
                            beat_cnt    <= '0;
                            if (run_end) begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                m_axis_tkeep  <= '0;
                                m_axis_tstrb  <= '0;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                state         <= IDLE;
                            end else if (cfg_gap == '0) begin
                                m_axis_tdata <= cfg_seed;
                                m_axis_tlast <= (cfg_len == ONE_L);
                            end else begin
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                                m_axis_tkeep  <= '0;
                                m_axis_tstrb  <= '0;
                                gap_cnt       <= cfg_gap - ONE_G;
                                state         <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (stop_now) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (gap_cnt == '0) begin
                        m_axis_tdata  <= cfg_seed;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (cfg_len == ONE_L);
                        m_axis_tkeep  <= KEEP_1;
                        m_axis_tstrb  <= KEEP_1;
                        state         <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - ONE_G;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen: directed and randomized runs scored against a
// frame-level reference model with a stream monitor.
module tb_axis_frame_gen;
    logic        aclk = 1'b0;
    logic        areset, start, stop;
    logic [1:0]  pattern;
    logic [31:0] seed;
    logic [15:0] frame_len;
    logic [7:0]  num_frames;
    logic [7:0]  gap;
    logic [31:0] tdata;
    logic        tvalid, tready, tlast;
    logic [3:0]  tkeep, tstrb;
    logic        busy, done;
    logic [15:0] frames_sent;

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_d[$];
    logic        got_l[$];
    int          gap_q[$];
    int          idle_run = 0;
    int          done_cnt = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l;

    axis_frame_gen dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .stop          (stop),
        .pattern       (pattern),
        .seed          (seed),
        .frame_len     (frame_len),
        .num_frames    (num_frames),
        .gap           (gap),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tkeep  (tkeep),
        .m_axis_tstrb  (tstrb),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    // Expected data of beat b of any frame, straight from the pattern rules.
    function automatic logic [31:0] model_beat(input logic [1:0] pat, input logic [31:0] sd,
                                               input int b);
        logic [31:0] d;
        case (pat)
            2'b01: return sd;
            2'b10: begin
                d = (sd == 32'd0) ? 32'd1 : sd;
                for (int i = 0; i < b; i++)
                    d = {1'b0, d[31:1]} ^ (d[0] ? 32'h80200003 : 32'h0);
                return d;
            end
            default: return sd + 32'(b);
        endcase
    endfunction

    // Stream monitor, sampled on the falling edge.
    always @(negedge aclk) begin
        if (areset) begin
            hold_pend = 1'b0;
            idle_run  = 0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 64'(tvalid), 64'd1);
                chk("hold_data", 64'(tdata), 64'(hold_d));
                chk("hold_last", 64'(tlast), 64'(hold_l));
            end
            hold_pend = tvalid && !tready;
            hold_d    = tdata;
            hold_l    = tlast;
            if (tvalid) begin
                chk("tkeep", 64'(tkeep), 64'hF);
                chk("tstrb", 64'(tstrb), 64'hF);
            end
            if (tvalid && tready) begin
                got_d.push_back(tdata);
                got_l.push_back(tlast);
            end
            if (done) done_cnt++;
            if (busy && !tvalid) idle_run++;
            else if (tvalid && idle_run != 0) begin
                gap_q.push_back(idle_run);
                idle_run = 0;
            end
        end
    end

    // mode 0: tready always 1; mode 1: random tready; mode 2: tready low in cycles 2..6.
    task automatic run(input logic [1:0] pat, input logic [31:0] sd, input int len, input int nf,
                       input int gp, input int mode, input int stop_k);
        int  len_eff, ef, nexp;
        bit  finished;
        len_eff  = (len == 0) ? 1 : len;
        ef       = (stop_k > 0) ? (stop_k / len_eff + 1) : nf;
        nexp     = ef * len_eff;
        finished = 1'b0;
        got_d.delete();
        got_l.delete();
        gap_q.delete();
        idle_run = 0;
        done_cnt = 0;

        pattern    = pat;
        seed       = sd;
        frame_len  = len[15:0];
        num_frames = nf[7:0];
        gap        = gp[7:0];
        tready     = 1'b1;
        start      = 1'b1;
        step;
        start = 1'b0;
        chk("latency_valid", 64'(tvalid), 64'd1);
        chk("first_data", 64'(tdata), 64'(model_beat(pat, sd, 0)));
        chk("busy_run", 64'(busy), 64'd1);
        // Config inputs wander while busy; the captured run must be unaffected.
        pattern    = 2'($urandom);
        seed       = $urandom;
        frame_len  = 16'($urandom_range(0, 9));
        num_frames = 8'($urandom_range(0, 9));
        gap        = 8'($urandom_range(0, 9));

        for (int cyc = 1; cyc < 5000 && !finished; cyc++) begin
            case (mode)
                1:       tready = ($urandom_range(0, 3) != 0);
                2:       tready = !(cyc >= 2 && cyc <= 6);
                default: tready = 1'b1;
            endcase
            start = (cyc == 3) && busy;
            stop  = (stop_k > 0) && (got_d.size() == stop_k);
            step;
            if (mode == 2 && cyc == 4) begin
                chk("stall_valid", 64'(tvalid), 64'd1);
                chk("stall_data", 64'(tdata), 64'(model_beat(pat, sd, 1)));
            end
            if (done) finished = 1'b1;
        end
        start  = 1'b0;
        stop   = 1'b0;
        tready = 1'b1;
        if (!finished) chk("run_timeout", 64'd0, 64'd1);
        step;
        step;

        chk("frames_sent", 64'(frames_sent), 64'(ef));
        chk("busy_end", 64'(busy), 64'd0);
        chk("valid_end", 64'(tvalid), 64'd0);
        chk("done_cycles", 64'(done_cnt), 64'd1);
        chk("beat_count", 64'(got_d.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < got_d.size(); i++) begin
            chk($sformatf("beat%0d_data", i), 64'(got_d[i]), 64'(model_beat(pat, sd, i % len_eff)));
            chk($sformatf("beat%0d_last", i), 64'(got_l[i]), 64'((i % len_eff) == len_eff - 1));
        end
        chk("gap_count", 64'(gap_q.size()), 64'((gp == 0) ? 0 : ef - 1));
        foreach (gap_q[i]) chk($sformatf("gap%0d_len", i), 64'(gap_q[i]), 64'(gp));
    endtask

    initial begin
        int len, k;
        areset     = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        tready     = 1'b0;
        pattern    = '0;
        seed       = '0;
        frame_len  = '0;
        num_frames = '0;
        gap        = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tkeep", 64'(tkeep), 64'd0);
        chk("rst_tstrb", 64'(tstrb), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_frames", 64'(frames_sent), 64'd0);
        areset = 1'b0;
        step;
        step;
        chk("idle_no_valid", 64'(tvalid), 64'd0);

        run(2'b00, 32'hAABBCCDD, 4, 1, 0, 0, 0);
        run(2'b00, 32'hAABBCCDD, 4, 1, 0, 2, 0);
        run(2'b10, 32'h00000001, 3, 2, 2, 0, 0);
        run(2'b00, 32'hFFFFFFFF, 0, 1, 0, 0, 0);
        run(2'b00, 32'hFFFFFFFF, 2, 1, 0, 0, 0);
        run(2'b00, 32'h12345678, 5, 0, 0, 0, 12);
        run(2'b01, 32'hCAFEF00D, 3, 2, 1, 1, 0);
        run(2'b10, 32'h00000000, 4, 1, 0, 0, 0);
        run(2'b11, 32'h0000FFFE, 3, 1, 0, 0, 0);

        for (int r = 0; r < 8; r++)
            run(2'($urandom), $urandom, $urandom_range(0, 6), $urandom_range(1, 4),
                $urandom_range(0, 3), 1, 0);
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(2, 5);
            k   = len * $urandom_range(1, 3) + $urandom_range(1, len - 1);
            run(2'($urandom), $urandom, len, 0, $urandom_range(0, 3), 1, k);
        end

        // Reset in the middle of a continuous run.
        pattern    = 2'b00;
        seed       = 32'h100;
        frame_len  = 16'd2;
        num_frames = 8'd0;
        gap        = 8'd0;
        tready     = 1'b1;
        start      = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        chk("pre_reset_frames", 64'(frames_sent), 64'd1);
        step;
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("async_tvalid", 64'(tvalid), 64'd0);
        chk("async_tlast", 64'(tlast), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_frames", 64'(frames_sent), 64'd0);
        chk("async_tdata", 64'(tdata), 64'd0);
        start = 1'b1;
        step;
        start  = 1'b0;
        areset = 1'b0;
        got_d.delete();
        for (int i = 0; i < 5; i++) begin
            step;
            chk("post_reset_valid", 64'(tvalid), 64'd0);
            chk("post_reset_busy", 64'(busy), 64'd0);
        end
        chk("post_reset_beats", 64'(got_d.size()), 64'd0);

        run(2'b00, 32'h00000010, 2, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_frame_gen.md
Name: axis_frame_gen

Overview:
AXI4-Stream master (transmitter) that generates framed test traffic. It drives the s_axis side of the stream processing block, or any other AXI-Stream slave. Software-style config (pattern, seed, frame length, frame count, inter-frame gap) is captured on a start pulse. The block then emits frames with tlast on the final beat and fully honours tready backpressure. It is both the upstream traffic source for the datapath and the stimulus engine for system-level benches.

Parameters:
DATA_WIDTH, 32, tdata width in bits; multiple of 8
LEN_WIDTH, 16, width of frame_len (beats per frame)
GAP_WIDTH, 8, width of gap (idle cycles between frames)
LFSR_POLY, 32'h80200003, Galois LFSR tap mask used in pattern 2

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; captures config and begins a run (IDLE only)
stop  in  1  level/pulse; ends the run after the current frame completes
pattern  in  2  00 incrementing, 01 constant, 10 LFSR, 11 treated as 00
seed  in  DATA_WIDTH  first data word of every frame
frame_len  in  LEN_WIDTH  beats per frame; 0 treated as 1
num_frames  in  8  frames per run; 0 = continuous until stop
gap  in  GAP_WIDTH  idle cycles (tvalid low) between frames
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready from slave
m_axis_tlast  out  1  high on the final beat of each frame
m_axis_tkeep  out  DATA_WIDTH/8  all ones whenever tvalid is high
m_axis_tstrb  out  DATA_WIDTH/8  equal to tkeep
busy  out  1  high in SEND or GAP
done  out  1  one-cycle pulse when a run ends
frames_sent  out  16  count of completed frames in the current run

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: tdata, tvalid, tlast, tkeep, tstrb, busy, done, frames_sent. Reset mid-frame aborts the frame immediately; tvalid dropping without a handshake is permitted in this case only.
- Handshake: a beat transfers on the rising edge where tvalid and tready are both 1.
  - Once tvalid is 1, tdata, tlast, tkeep and tstrb hold stable until that beat transfers.
  - tvalid never depends combinationally on tready.
  - All outputs are registered.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - start=1 latches pattern, seed, frame_len (0 becomes 1), num_frames and gap.
  - It clears frames_sent, loads beat_cnt=0 and data=seed, and goes to SEND.
  - tvalid is 1 in the cycle after the start edge (latency 1).
  - start while busy is ignored; config changes while busy are ignored.
- SEND, on each handshake:
  - If not the last beat: beat_cnt+1 and data advances per pattern.
  - Last beat (beat_cnt == frame_len-1): tlast=1 on that beat; frames_sent+1, wrapping mod 2^16.
- Pattern advance:
  - 00: data+1, wrapping mod 2^DATA_WIDTH.
  - 01: data unchanged.
  - 10: data = (data>>1) ^ (data[0] ? LFSR_POLY : 0). A seed of 0 is replaced by 1 at capture.
- After the last-beat handshake:
  - Run ends if stop has been seen, or num_frames!=0 and frames_sent reaches num_frames.
    - Go to IDLE with tvalid=0; done=1 for the next cycle only; busy=0.
  - Else, if gap==0: stay in SEND with tvalid continuously 1; the next beat is beat 0 = seed.
  - Else go to GAP: tvalid=0 for exactly gap cycles, then SEND with beat 0 = seed.
- Data restarts at seed for every frame.
- stop:
  - Latched into a sticky flag while busy; the flag is cleared on start.
  - It never truncates a frame.
  - stop during GAP: go directly to IDLE, pulse done, emit no further frame.
  - stop in the same cycle as the last-beat handshake counts for that frame.
- Backpressure: tready low for any number of cycles stalls beat_cnt, data and frames_sent. Nothing is dropped or duplicated.
- start and areset together: reset wins.

Test Plan:
- Pass-through length: pattern=00, seed=0xAABBCCDD, frame_len=4, num_frames=1, gap=0, tready=1 -> beats AABBCCDD, AABBCCDE, AABBCCDF, AABBCCE0 on consecutive cycles; tlast on the 4th; done one cycle later; frames_sent=1.
- Backpressure: same config, tready=0 for cycles 2-6 after start -> tdata holds AABBCCDE and tvalid stays 1 throughout the stall; 4 beats total, no duplicates.
- LFSR + gap: pattern=10, seed=1, frame_len=3, num_frames=2, gap=2 -> frame data 00000001, 80200003, C0300002 twice; exactly 2 cycles of tvalid=0 between frames; frames_sent=2.
- Length-0 / wrap: pattern=00, seed=0xFFFFFFFF, frame_len=0 -> single beat FFFFFFFF with tlast=1; with frame_len=2 the second beat is 00000000.
- Continuous + stop: num_frames=0, frame_len=5, stop pulsed on beat 2 of frame 3 -> frame 3 completes with tlast; no frame 4; done pulses; frames_sent=3.
- Reset mid-frame: assert areset during beat 2 -> tvalid, tlast, busy and frames_sent go to 0 asynchronously; after release, start is needed before any new traffic.
